axi4_lite_rd_seq: RTL and testbench
===================================

AXI4_LITE_RD_SEQ -- requirements
Module: axi4_lite_rd_seq

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, meaning output FIFO depth in 32-bit words (power of two, 2..16).
REQ-002 Parameter ADDR_STEP, default 4, meaning byte increment between consecutive read addresses.
REQ-003 m_aclk  input  1  single clock; all logic on its rising edge.
REQ-004 m_arst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle command strobe.
REQ-006 base_addr  input  32  first read address, sampled with start.
REQ-007 num_words  input  16  number of single-beat reads, sampled with start.
REQ-008 busy  output  1  high from accepted start until done.
REQ-009 done  output  1  one-cycle pulse at command completion.
REQ-010 rd_addr  output  32  address to the single-beat read engine.
REQ-011 rd_valid  output  1  read request to the read engine.
REQ-012 rd_data  input  32  read data, valid only while rd_ready is high.
REQ-013 rd_ready  input  1  one-cycle completion pulse from the read engine.
REQ-014 out_data  output  32  stream data, FIFO head.
REQ-015 out_valid  output  1  stream valid, i.e. FIFO not empty.
REQ-016 out_ready  input  1  stream consumer ready.

Function
REQ-017 States: IDLE, CHECK, ISSUE, FINISH.
REQ-018 IDLE: start=1 latches base_addr into addr_r and num_words into remaining_r, sets busy, and moves to CHECK.
REQ-019 start SHALL be ignored whenever busy=1.
REQ-020 CHECK: remaining_r=0 moves to FINISH; otherwise, if FIFO free slots >= 1, the block moves to ISSUE and registers rd_valid=1 with rd_addr=addr_r; otherwise it stays in CHECK.
REQ-021 ISSUE: rd_valid and rd_addr SHALL be held stable until the cycle rd_ready=1.
REQ-022 On the edge where rd_ready=1: rd_valid cleared (registered), rd_data written to FIFO, addr_r += ADDR_STEP (mod 2^32, wrap silently), remaining_r -= 1, next state CHECK.
REQ-023 At most one read SHALL be outstanding; rd_valid SHALL never be high in the cycle after rd_ready=1.
REQ-024 FINISH: done=1 for exactly one cycle, busy cleared, next state IDLE. num_words=0 therefore yields done 2 cycles after start with no rd_valid.
REQ-025 done does not wait for FIFO drain; the FIFO contents remain readable after done.
REQ-026 FIFO write and read in the same cycle SHALL both succeed, count unchanged, including when full.
REQ-027 out_data/out_valid SHALL be registered FIFO outputs; a pop occurs on out_valid&&out_ready.
REQ-028 The back-pressure rule in REQ-020 guarantees no FIFO overflow; a write when full SHALL be impossible by construction.
REQ-029 rd_ready outside ISSUE SHALL be ignored.

Reset
REQ-030 Reset asserted: state IDLE, busy=0, done=0, rd_valid=0, rd_addr=0, addr_r=0, remaining_r=0, FIFO empty, out_valid=0, out_data=0.
REQ-031 Reset mid-command SHALL abort immediately with no done pulse; buffered data is discarded.

Structure
REQ-032 State encodings and ADDR_STEP default SHALL live in the shared package axi_user_pkg.
REQ-033 The FIFO SHALL be the sub-module sync_fifo (parameters WIDTH and DEPTH; ports push, pop, din, dout, full, empty, count).
REQ-034 Design size SHALL be about 150-300 lines.

Verification
REQ-035 Stimulus: base=0x1000, n=3, out_ready=1, engine responds in 3 cycles. Required: rd_addr 0x1000/0x1004/0x1008 in order, three stream beats in order, one done.
REQ-036 Stimulus: n=0. Required: no rd_valid, done 2 cycles after start, busy high for 2 cycles.
REQ-037 Stimulus: n=8, FIFO_DEPTH=4, out_ready=0. Required: exactly 4 reads issued, then the block stalls in CHECK; after out_ready=1, all 8 words are delivered, none lost.
REQ-038 Stimulus: base=0xFFFFFFFC, n=2. Required: rd_addr 0xFFFFFFFC then 0x00000000.
REQ-039 Stimulus: start pulsed while busy, then reset asserted during ISSUE. Required: second start ignored; after reset all outputs at reset values and no done.
REQ-040 Stimulus: push and pop in the same cycle with the FIFO full. Required: count stays at 4 and order is preserved.

Source files
------------

// File: rtl/axi_user_pkg.sv
// Shared definitions for the single-beat read sequencer: FSM encodings and defaults.
package axi_user_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_FINISH = 2'd3
    } rd_seq_state_e;

    localparam int unsigned ADDR_STEP_DEFAULT  = 4;
    localparam int unsigned FIFO_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head-of-queue output (show-ahead).
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_ptr_n;
    logic [PW:0]      count_n;
    logic [WIDTH-1:0] dout_n;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    always_comb begin
        rd_ptr_n = rd_ptr + PW'(pop_ok);
        count_n  = count + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
        dout_n   = dout;
        if (count_n != '0) begin
            // The next head is either the word being written now or already in storage.
            if (push_ok && (wr_ptr == rd_ptr_n)) begin
                dout_n = din;
            end else begin
                dout_n = mem[rd_ptr_n];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr <= rd_ptr_n;
            count  <= count_n;
            dout   <= dout_n;
        end
    end

endmodule

// File: rtl/axi4_lite_rd_seq.sv
// Issues num_words single-beat reads from base_addr and streams the returned data
// through a FIFO; reads are only issued while the FIFO has room for the result.
module axi4_lite_rd_seq
    import axi_user_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int unsigned ADDR_STEP  = ADDR_STEP_DEFAULT
) (
    input  logic                          m_aclk,
    input  logic                          m_arst_n,
    input  logic                          start,
    input  logic [31:0]                   base_addr,
    input  logic [15:0]                   num_words,
    output logic                          busy,
    output logic                          done,
    output logic [31:0]                   rd_addr,
    output logic                          rd_valid,
    input  logic [31:0]                   rd_data,
    input  logic                          rd_ready,
    output logic [31:0]                   out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output rd_seq_state_e                 dbg_state,
    output logic [$clog2(FIFO_DEPTH):0]   dbg_fifo_count
);

    // Handshakes: rd_valid/rd_addr are registered and held until the engine returns a
    // one-cycle rd_ready (rd_data valid in that cycle); a stream beat transfers on the
    // rising edge where out_valid && out_ready are both high.

    rd_seq_state_e state, state_n;
    logic [31:0]   addr_r, addr_n;
    logic [15:0]   remaining_r, remaining_n;
    logic [31:0]   rd_addr_n;
    logic          rd_valid_n;
    logic          busy_n;
    logic          done_n;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;

    assign dbg_state = state;
    assign out_valid = !fifo_empty;
    assign fifo_pop  = out_valid && out_ready;

    always_comb begin
        state_n     = state;
        addr_n      = addr_r;
        remaining_n = remaining_r;
        rd_addr_n   = rd_addr;
        rd_valid_n  = rd_valid;
        busy_n      = busy;
        done_n      = 1'b0;
        fifo_push   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    addr_n      = base_addr;
                    remaining_n = num_words;
                    busy_n      = 1'b1;
                    state_n     = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (remaining_r == '0) begin
                    done_n  = 1'b1;
                    state_n = ST_FINISH;
                end else if (!fifo_full) begin
                    // One free slot guarantees the returning word has a place to land.
                    rd_valid_n = 1'b1;
                    rd_addr_n  = addr_r;
                    state_n    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (rd_ready) begin
                    rd_valid_n  = 1'b0;
                    fifo_push   = 1'b1;
                    addr_n      = addr_r + ADDR_STEP;
                    remaining_n = remaining_r - 16'd1;
                    state_n     = ST_CHECK;
                end
            end
            ST_FINISH: begin
                busy_n  = 1'b0;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge m_aclk or negedge m_arst_n) begin
        if (!m_arst_n) begin
            state       <= ST_IDLE;
            addr_r      <= '0;
            remaining_r <= '0;
            rd_addr     <= '0;
            rd_valid    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            addr_r      <= addr_n;
            remaining_r <= remaining_n;
            rd_addr     <= rd_addr_n;
            rd_valid    <= rd_valid_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end

    sync_fifo #(
        .WIDTH(32),
        .DEPTH(int'(FIFO_DEPTH))
    ) u_fifo (
        .clk   (m_aclk),
        .rst_n (m_arst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (rd_data),
        .dout  (out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (dbg_fifo_count)
    );

endmodule

// File: tb/tb_axi4_lite_rd_seq.sv
// Directed bench for axi4_lite_rd_seq plus a standalone sync_fifo full-throughput case.
module tb_axi4_lite_rd_seq;
    import axi_user_pkg::*;

    localparam logic [31:0] DATA_KEY = 32'hA5A5_5A5A;

    // ---------------- clock / reset ----------------
    logic          m_aclk    = 1'b0;
    logic          m_arst_n  = 1'b0;
    logic          start     = 1'b0;
    logic [31:0]   base_addr = '0;
    logic [15:0]   num_words = '0;
    logic          busy;
    logic          done;
    logic [31:0]   rd_addr;
    logic          rd_valid;
    logic [31:0]   rd_data   = '0;
    logic          rd_ready  = 1'b0;
    logic [31:0]   out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    rd_seq_state_e dbg_state;
    logic [2:0]    dbg_fifo_count;

    logic          f_push = 1'b0;
    logic          f_pop  = 1'b0;
    logic [31:0]   f_din  = '0;
    logic [31:0]   f_dout;
    logic          f_full;
    logic          f_empty;
    logic [2:0]    f_count;

    always #5 m_aclk = ~m_aclk;

    axi4_lite_rd_seq #(
        .FIFO_DEPTH(4),
        .ADDR_STEP (4)
    ) dut (
        .m_aclk         (m_aclk),
        .m_arst_n       (m_arst_n),
        .start          (start),
        .base_addr      (base_addr),
        .num_words      (num_words),
        .busy           (busy),
        .done           (done),
        .rd_addr        (rd_addr),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .rd_ready       (rd_ready),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .dbg_state      (dbg_state),
        .dbg_fifo_count (dbg_fifo_count)
    );

    sync_fifo #(
        .WIDTH(32),
        .DEPTH(4)
    ) u_fifo_alone (
        .clk   (m_aclk),
        .rst_n (m_arst_n),
        .push  (f_push),
        .pop   (f_pop),
        .din   (f_din),
        .dout  (f_dout),
        .full  (f_full),
        .empty (f_empty),
        .count (f_count)
    );

    int          checks    = 0;
    int          failures  = 0;
    int          done_cnt  = 0;
    int          rdv_cycles = 0;
    int          proto_err = 0;
    bit          prev_rdy  = 1'b0;
    bit          eng_en    = 1'b0;
    int          eng_wait  = 0;
    logic [31:0] addr_q[$];
    logic [31:0] got_q[$];

    // ---------------- read engine model: answers on the 3rd cycle of rd_valid ----------------
    initial begin
        forever begin
            @(negedge m_aclk);
            rd_ready = 1'b0;
            if (eng_en && rd_valid && m_arst_n) begin
                eng_wait++;
                if (eng_wait == 3) begin
                    rd_ready = 1'b1;
                    rd_data  = rd_addr ^ DATA_KEY;
                    addr_q.push_back(rd_addr);
                    eng_wait = 0;
                end
            end else begin
                eng_wait = 0;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge m_aclk);
            #1;
            if (out_valid && out_ready) got_q.push_back(out_data);
            if (done) done_cnt++;
            if (rd_valid) rdv_cycles++;
            if (prev_rdy && rd_valid) proto_err++;
            prev_rdy = rd_ready;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic start_cmd(input logic [31:0] base, input logic [15:0] n);
        @(negedge m_aclk);
        start     = 1'b1;
        base_addr = base;
        num_words = n;
        @(negedge m_aclk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int max_cyc, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge m_aclk);
            #2;
            if (done_cnt >= target) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_state(input rd_seq_state_e st, input int max_cyc, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge m_aclk);
            #2;
            if (dbg_state == st) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        m_arst_n  = 1'b0;
        eng_en    = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge m_aclk);
        #2;
        checks++;
        if ({busy, done, rd_valid, out_valid} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags: busy/done/rd_valid/out_valid got %b want 0000", {busy, done, rd_valid, out_valid});
        end
        checks++;
        if (rd_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_rd_addr: got %h want 00000000", rd_addr);
        end
        checks++;
        if (out_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_out_data: got %h want 00000000", out_data);
        end
        checks++;
        if (dbg_state !== ST_IDLE || dbg_fifo_count !== 3'd0) begin
            failures++;
            $display("FAIL reset_state: state %0d count %0d want 0/0", dbg_state, dbg_fifo_count);
        end
        @(negedge m_aclk);
        m_arst_n = 1'b1;
        repeat (2) @(negedge m_aclk);
    endtask

    task automatic check_run(input string name, input logic [31:0] base, input int n, input int d0);
        logic [31:0] exp_a;
        logic [31:0] got;
        checks++;
        if (addr_q.size() != n) begin
            failures++;
            $display("FAIL %s_nreads: got %0d want %0d", name, addr_q.size(), n);
        end
        checks++;
        if (got_q.size() != n) begin
            failures++;
            $display("FAIL %s_nbeats: got %0d want %0d", name, got_q.size(), n);
        end
        for (int i = 0; i < n; i++) begin
            exp_a = base + 32'(4 * i);
            got   = (i < addr_q.size()) ? addr_q[i] : 32'hDEAD_BEEF;
            checks++;
            if (got !== exp_a) begin
                failures++;
                $display("FAIL %s_addr[%0d]: got %h want %h", name, i, got, exp_a);
            end
            got = (i < got_q.size()) ? got_q[i] : 32'hDEAD_BEEF;
            checks++;
            if (got !== (exp_a ^ DATA_KEY)) begin
                failures++;
                $display("FAIL %s_data[%0d]: got %h want %h", name, i, got, exp_a ^ DATA_KEY);
            end
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL %s_done_count: got %0d want 1", name, done_cnt - d0);
        end
        checks++;
        if (proto_err != 0) begin
            failures++;
            $display("FAIL %s_rd_valid_after_ready: got %0d want 0", name, proto_err);
        end
    endtask

    task automatic test_basic();
        int d0;
        bit to;
        addr_q.delete();
        got_q.delete();
        d0        = done_cnt;
        eng_en    = 1'b1;
        out_ready = 1'b1;
        start_cmd(32'h0000_1000, 16'd3);
        wait_done(d0 + 1, 100, to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL basic_timeout: done got 0 want 1 within 100 cycles");
        end
        repeat (6) @(negedge m_aclk);
        #2;
        check_run("basic", 32'h0000_1000, 3, d0);
    endtask

    task automatic test_zero();
        int d0;
        int v0;
        d0 = done_cnt;
        v0 = rdv_cycles;
        @(negedge m_aclk);
        start     = 1'b1;
        base_addr = 32'h0000_5000;
        num_words = 16'd0;
        @(negedge m_aclk);
        start = 1'b0;
        #2;
        checks++;
        if ({busy, done} !== 2'b10) begin
            failures++;
            $display("FAIL zero_cycle1: busy/done got %b want 10", {busy, done});
        end
        @(negedge m_aclk);
        #2;
        checks++;
        if ({busy, done} !== 2'b11) begin
            failures++;
            $display("FAIL zero_cycle2: busy/done got %b want 11", {busy, done});
        end
        @(negedge m_aclk);
        #2;
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL zero_cycle3: busy/done got %b want 00", {busy, done});
        end
        checks++;
        if (rdv_cycles != v0 || done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL zero_activity: rd_valid cycles %0d dones %0d want 0/1", rdv_cycles - v0, done_cnt - d0);
        end
    endtask

    task automatic test_backpressure();
        int d0;
        bit to;
        addr_q.delete();
        got_q.delete();
        d0        = done_cnt;
        eng_en    = 1'b1;
        out_ready = 1'b0;
        start_cmd(32'h0000_2000, 16'd8);
        repeat (60) @(negedge m_aclk);
        #2;
        checks++;
        if (addr_q.size() != 4) begin
            failures++;
            $display("FAIL bp_reads_while_stalled: got %0d want 4", addr_q.size());
        end
        checks++;
        if (dbg_state !== ST_CHECK || dbg_fifo_count !== 3'd4 || busy !== 1'b1) begin
            failures++;
            $display("FAIL bp_stall_state: state %0d count %0d busy %b want 1/4/1", dbg_state, dbg_fifo_count, busy);
        end
        checks++;
        if (got_q.size() != 0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_no_beats: beats %0d out_valid %b want 0/1", got_q.size(), out_valid);
        end
        @(negedge m_aclk);
        out_ready = 1'b1;
        wait_done(d0 + 1, 300, to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL bp_timeout: done got 0 want 1 within 300 cycles");
        end
        repeat (8) @(negedge m_aclk);
        #2;
        check_run("bp", 32'h0000_2000, 8, d0);
        checks++;
        if (dbg_fifo_count !== 3'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_drained: count %0d out_valid %b want 0/0", dbg_fifo_count, out_valid);
        end
    endtask

    task automatic test_wrap();
        int d0;
        bit to;
        addr_q.delete();
        got_q.delete();
        d0        = done_cnt;
        eng_en    = 1'b1;
        out_ready = 1'b1;
        start_cmd(32'hFFFF_FFFC, 16'd2);
        wait_done(d0 + 1, 100, to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL wrap_timeout: done got 0 want 1 within 100 cycles");
        end
        repeat (6) @(negedge m_aclk);
        #2;
        check_run("wrap", 32'hFFFF_FFFC, 2, d0);
    endtask

    task automatic test_busy_reset();
        int d0;
        bit to;
        addr_q.delete();
        got_q.delete();
        d0        = done_cnt;
        eng_en    = 1'b1;
        out_ready = 1'b1;
        start_cmd(32'h0000_3000, 16'd4);
        wait_state(ST_ISSUE, 20, to);
        checks++;
        if (to || busy !== 1'b1) begin
            failures++;
            $display("FAIL br_first_issue: timeout %b busy %b want 0/1", to, busy);
        end
        @(negedge m_aclk);
        start     = 1'b1;
        base_addr = 32'h0000_9000;
        num_words = 16'd1;
        @(negedge m_aclk);
        start = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge m_aclk);
            #2;
            if (addr_q.size() >= 2) begin
                to = 1'b0;
                break;
            end
        end
        checks++;
        if (to || addr_q[1] !== 32'h0000_3004 || addr_q[0] !== 32'h0000_3000) begin
            failures++;
            $display("FAIL br_start_ignored: timeout %b second addr %h want 00003004", to, (addr_q.size() >= 2) ? addr_q[1] : 32'hDEAD_BEEF);
        end
        @(negedge m_aclk);
        wait_state(ST_ISSUE, 20, to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL br_second_issue: timeout got 1 want 0");
        end
        @(negedge m_aclk);
        m_arst_n = 1'b0;
        #2;
        checks++;
        if ({busy, done, rd_valid, out_valid} !== 4'b0000 || rd_addr !== 32'h0 || out_data !== 32'h0) begin
            failures++;
            $display("FAIL br_reset_outputs: flags %b rd_addr %h out_data %h want 0000/0/0", {busy, done, rd_valid, out_valid}, rd_addr, out_data);
        end
        checks++;
        if (dbg_state !== ST_IDLE || dbg_fifo_count !== 3'd0) begin
            failures++;
            $display("FAIL br_reset_state: state %0d count %0d want 0/0", dbg_state, dbg_fifo_count);
        end
        repeat (3) @(negedge m_aclk);
        m_arst_n = 1'b1;
        repeat (10) @(negedge m_aclk);
        #2;
        checks++;
        if (done_cnt != d0 || busy !== 1'b0 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL br_after_reset: dones %0d busy %b rd_valid %b want 0/0/0", done_cnt - d0, busy, rd_valid);
        end
    endtask

    task automatic test_fifo_full();
        logic [31:0] vals[5];
        vals[0] = 32'h1111_0001;
        vals[1] = 32'h2222_0002;
        vals[2] = 32'h3333_0003;
        vals[3] = 32'h4444_0004;
        vals[4] = 32'h5555_0005;
        for (int i = 0; i < 4; i++) begin
            @(negedge m_aclk);
            f_push = 1'b1;
            f_din  = vals[i];
        end
        @(negedge m_aclk);
        f_push = 1'b0;
        #2;
        checks++;
        if (f_count !== 3'd4 || f_full !== 1'b1 || f_dout !== vals[0]) begin
            failures++;
            $display("FAIL fifo_fill: count %0d full %b head %h want 4/1/%h", f_count, f_full, f_dout, vals[0]);
        end
        @(negedge m_aclk);
        f_push = 1'b1;
        f_pop  = 1'b1;
        f_din  = vals[4];
        @(negedge m_aclk);
        f_push = 1'b0;
        f_pop  = 1'b0;
        #2;
        checks++;
        if (f_count !== 3'd4 || f_full !== 1'b1) begin
            failures++;
            $display("FAIL fifo_full_push_pop: count %0d full %b want 4/1", f_count, f_full);
        end
        for (int i = 1; i < 5; i++) begin
            checks++;
            if (f_dout !== vals[i]) begin
                failures++;
                $display("FAIL fifo_order[%0d]: got %h want %h", i, f_dout, vals[i]);
            end
            @(negedge m_aclk);
            f_pop = 1'b1;
            @(negedge m_aclk);
            f_pop = 1'b0;
            #2;
        end
        checks++;
        if (f_empty !== 1'b1 || f_count !== 3'd0) begin
            failures++;
            $display("FAIL fifo_empty_after: empty %b count %0d want 1/0", f_empty, f_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_backpressure();
        test_wrap();
        test_busy_reset();
        test_fifo_full();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
